alu_exec: RTL and testbench

Execution end of the controller/ALU op interface. It accepts one operation per handshake: a 3-bit alu_op and a 4-bit state tag from the sequencing controller, plus two operands. It runs them through a 2-stage valid/ready pipeline and returns the result, flags and the tag. It also checks that the incoming op stream advances by exactly one per accepted operation, mod 8, and reports violations.

---
 rtl/alu_exec.sv | 162 ++++++++++++++++
 tb/tb_alu_exec.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execution end of the controller/ALU op interface: two-stage valid/ready
// ALU pipeline with op-sequence checking and a saturating delivery counter.
module alu_exec #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [3:0]       state,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [3:0]       out_tag,
  output logic             seq_err,
  output logic [15:0]      op_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic {
    SEQ_EMPTY,
    SEQ_TRACK
  } seq_e;

  logic             v1;
  op_e              op1;
  logic [3:0]       tag1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             v2;

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             deliver;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_n;
  logic             carry_n;
  logic             zero_n;

  seq_e             seq_st;
  logic [2:0]       last_op;

  // Ready depends only on registered valids and out_ready, never on in_valid.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign accept    = in_valid && in_ready;
  assign deliver   = v2 && out_ready;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      op1  <= OP_ADD;
      tag1 <= '0;
      a1   <= '0;
      b1   <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        op1  <= op_e'(alu_op);
        tag1 <= state;
        a1   <= a;
        b1   <= b;
      end
    end
  end

  always_comb begin
    sum     = {1'b0, a1} + {1'b0, b1};
    diff    = {1'b0, a1} - {1'b0, b1};
    res_n   = '0;
    carry_n = 1'b0;
    unique case (op1)
      OP_ADD: begin
        res_n   = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      OP_SUB: begin
        res_n   = diff[WIDTH-1:0];
        carry_n = diff[WIDTH];
      end
      OP_AND: res_n = a1 & b1;
      OP_OR:  res_n = a1 | b1;
      OP_XOR: res_n = a1 ^ b1;
      OP_SHL: begin
        res_n   = {a1[WIDTH-2:0], 1'b0};
        carry_n = a1[WIDTH-1];
      end
      OP_SHR: begin
        res_n   = {1'b0, a1[WIDTH-1:1]};
        carry_n = a1[0];
      end
      OP_CMP: begin
        res_n   = '0;
        carry_n = diff[WIDTH];
      end
    endcase
    zero_n = (op1 == OP_CMP) ? (a1 == b1) : (res_n == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2      <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      out_tag <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        result  <= res_n;
        carry   <= carry_n;
        zero    <= zero_n;
        out_tag <= tag1;
      end
    end
  end

  // The last op is always overwritten so a single bad op flags once and the
  // checker then tracks the new sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_st  <= SEQ_EMPTY;
      last_op <= '0;
      seq_err <= 1'b0;
    end else if (accept) begin
      if (seq_st == SEQ_TRACK && alu_op != 3'(last_op + 3'd1)) begin
        seq_err <= 1'b1;
      end
      last_op <= alu_op;
      seq_st  <= SEQ_TRACK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (deliver && op_count != '1) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results are queued at accept and
// compared at delivery, with per-scenario tasks for sequencing and stalls.
module tb_alu_exec;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [3:0]   state;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic [3:0]   out_tag;
  logic         seq_err;
  logic [15:0]  op_count;

  alu_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .state     (state),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .out_tag   (out_tag),
    .seq_err   (seq_err),
    .op_count  (op_count)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic [3:0]   tag;
    int unsigned  acc;
  } exp_t;

  exp_t         sb[$];
  int unsigned  vectors     = 0;
  int unsigned  miscompares = 0;
  int unsigned  cyc         = 0;
  int unsigned  delivered   = 0;
  int unsigned  accepts     = 0;
  bit           lat_check   = 0;
  bit           stall_seen  = 0;
  int unsigned  stall_accepts = 0;
  bit           held_valid  = 0;
  logic [W-1:0] held_res;
  logic [3:0]   held_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [2:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, output logic [W-1:0] r,
                                output logic c, output logic z);
    logic [W:0] s;
    c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = x << 1; c = x[W-1]; end
      3'd6: begin r = x >> 1; c = x[0]; end
      default: begin r = '0; c = (x < y); end
    endcase
    z = (op == 3'd7) ? (x == y) : (r == '0);
  endfunction

  // Delivery monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL deliver_unexpected: got res=%h tag=%h, expected no result", result, out_tag);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || carry !== e.c || zero !== e.z || out_tag !== e.tag) begin
          miscompares++;
          $display("FAIL deliver: got res=%h c=%b z=%b tag=%h, expected res=%h c=%b z=%b tag=%h",
                   result, carry, zero, out_tag, e.res, e.c, e.z, e.tag);
        end
        if (lat_check) begin
          vectors++;
          if (cyc - e.acc !== 2) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, expected 2", cyc - e.acc);
          end
        end
      end
      delivered++;
    end
    if (reset_n && out_valid && !out_ready) begin
      if (held_valid) begin
        vectors++;
        if (result !== held_res || out_tag !== held_tag) begin
          miscompares++;
          $display("FAIL stall_hold: got res=%h tag=%h, expected res=%h tag=%h",
                   result, out_tag, held_res, held_tag);
        end
      end
      held_valid = 1;
      held_res   = result;
      held_tag   = out_tag;
    end else begin
      held_valid = 0;
    end
  end

  task automatic send_op(input logic [2:0] op, input logic [3:0] tag,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic ec, input logic ez);
    int unsigned waited = 0;
    exp_t e;
    in_valid = 1'b1;
    alu_op   = op;
    state    = tag;
    a        = av;
    b        = bv;
    @(negedge clk);
    while (!in_ready) begin
      if (!stall_seen) begin
        stall_seen    = 1;
        stall_accepts = accepts;
      end
      waited++;
      if (waited > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.res = er; e.c = ec; e.z = ez; e.tag = tag; e.acc = cyc;
    sb.push_back(e);
    accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input logic [2:0] op, input logic [3:0] tag,
                            input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] r;
    logic c, z;
    model(op, av, bv, r, c, z);
    send_op(op, tag, av, bv, r, c, z);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned budget = 0;
    idle();
    while (sb.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 3'd3;
    #2 reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, result, carry, zero, out_tag, seq_err, op_count} !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b r=%h c=%b z=%b t=%h e=%b n=%h rdy=%b, expected all 0 rdy=1",
               out_valid, result, carry, zero, out_tag, seq_err, op_count, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_release: got v=%b rdy=%b n=%h, expected v=0 rdy=1 n=0", out_valid, in_ready, op_count);
    end
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] exp_r [8] = '{8'h10, 8'hD0, 8'h20, 8'hF0, 8'hD0, 8'hE0, 8'h78, 8'h00};
    logic [7:0]   exp_c = 8'b0010_0001;
    apply_reset();
    lat_check = 1;
    for (int i = 0; i < 8; i++) begin
      send_op(3'(i), 4'(i), 8'hF0, 8'h20, exp_r[i], exp_c[i], 1'b0);
    end
    drain();
    lat_check = 0;
    vectors++;
    if (op_count !== 16'd8 || seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_count: got n=%0d e=%b, expected n=8 e=0", op_count, seq_err);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int unsigned base;
    apply_reset();
    out_ready  = 1'b0;
    stall_seen = 0;
    accepts    = 0;
    base       = delivered;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_model(3'(i), 4'(i + 8), W'($urandom), W'($urandom));
        end
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (!stall_seen || stall_accepts !== 2) begin
      miscompares++;
      $display("FAIL bp_stall: got stall=%b after %0d accepts, expected stall after 2", stall_seen, stall_accepts);
    end
    vectors++;
    if (op_count !== 16'd6 || delivered - base !== 6) begin
      miscompares++;
      $display("FAIL bp_count: got n=%0d delivered=%0d, expected 6", op_count, delivered - base);
    end
  endtask

  task automatic test_seq_error();
    apply_reset();
    send_model(3'd0, 4'd1, W'($urandom), W'($urandom));
    send_model(3'd1, 4'd2, W'($urandom), W'($urandom));
    vectors++;
    if (seq_err !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_in_order: got seq_err=%b, expected 0", seq_err);
    end
    send_model(3'd3, 4'd3, W'($urandom), W'($urandom));
    vectors++;
    if (seq_err !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_skip: got seq_err=%b, expected 1", seq_err);
    end
    send_model(3'd4, 4'd4, W'($urandom), W'($urandom));
    drain();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (seq_err !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_sticky: got seq_err=%b, expected 1", seq_err);
    end
  endtask

  task automatic test_wrap_edge();
    apply_reset();
    send_model(3'd6, 4'd6, 8'h05, 8'h05);
    send_op(3'd7, 4'd7, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1);
    send_op(3'd0, 4'd0, 8'h05, 8'h05, 8'h0A, 1'b0, 1'b0);
    drain();
    vectors++;
    if (seq_err !== 1'b0 || op_count !== 16'd3) begin
      miscompares++;
      $display("FAIL wrap: got seq_err=%b n=%0d, expected seq_err=0 n=3", seq_err, op_count);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    out_ready = 1'b0;
    send_model(3'd2, 4'd5, W'($urandom), W'($urandom));
    send_model(3'd4, 4'd6, W'($urandom), W'($urandom));
    idle();
    vectors++;
    if (seq_err !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_prep: got seq_err=%b v=%b, expected 1 1", seq_err, out_valid);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || seq_err !== 1'b0 || result !== '0 || out_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_async: got v=%b e=%b r=%h t=%h, expected all 0", out_valid, seq_err, result, out_tag);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_model(3'd0, 4'd9, W'($urandom), W'($urandom));
    send_model(3'd1, 4'd10, W'($urandom), W'($urandom));
    drain();
    vectors++;
    if (seq_err !== 1'b0 || op_count !== 16'd2) begin
      miscompares++;
      $display("FAIL mid_unchecked: got seq_err=%b n=%0d, expected 0 2", seq_err, op_count);
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = '0;
    state     = '0;
    a         = '0;
    b         = '0;
    test_reset();
    test_op_sweep();
    test_back_to_back_backpressure();
    test_seq_error();
    test_wrap_edge();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
